// File: rtl/remap_bank_cache.sv
// rtl/remap_bank_cache.sv - XOR-remapped banked read cache, multi-round conflict issue with lane broadcast.
// Define REMAP_CACHE_WBYPASS_EN to forward same-cycle write data to a colliding read.
module remap_bank_cache #(
  parameter int LBW    = 6,
  parameter int DBW    = 16,
  parameter int VSIZE  = 4,
  parameter int N_ICFG = 4,
  localparam int CV_BW   = $clog2(VSIZE),
  localparam int HBW     = LBW - CV_BW,
  localparam int ICFG_BW = $clog2(N_ICFG + 1),
  localparam int SBW     = $clog2(HBW + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [N_ICFG-1:0][CV_BW-1:0]    i_xor_masks,
  input  logic [N_ICFG-1:0][SBW-1:0]      i_xor_shifts,
  input  logic                            ra_rdy,
  output logic                            ra_ack,
  input  logic [ICFG_BW-1:0]              i_rid,
  input  logic [VSIZE-1:0][LBW-1:0]       i_raddr,
  input  logic                            i_retire,
  input  logic [1:0]                      i_syst_type,
  output logic                            rd_rdy,
  input  logic                            rd_ack,
  output logic [1:0]                      o_syst_type,
  output logic [VSIZE-1:0][DBW-1:0]       o_rdata,
  output logic                            free_dval,
  output logic [ICFG_BW-1:0]              o_free_id,
  output logic [15:0]                     o_conflict_cnt,
  input  logic                            wad_dval,
  input  logic [ICFG_BW-1:0]              i_wid,
  input  logic [HBW-1:0]                  i_whiaddr,
  input  logic [VSIZE-1:0][DBW-1:0]       i_wdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]                   state;
  logic [VSIZE-1:0][LBW-1:0]    addr_q;
  logic [ICFG_BW-1:0]           rid_q;
  logic                         retire_q;
  logic [VSIZE-1:0]             pending;
  logic [VSIZE-1:0]             served_q;
  logic [VSIZE-1:0][CV_BW-1:0]  lane_bank_q;
  logic [CV_BW:0]               rounds;

  logic [CV_BW-1:0]             rmask, wmask;
  logic [SBW-1:0]               rshift, wshift;
  logic [CV_BW-1:0]             wx;
  logic [VSIZE-1:0][CV_BW-1:0]  lane_bank;
  logic [VSIZE-1:0][HBW-1:0]    lane_row;
  logic [VSIZE-1:0][HBW-1:0]    bank_row;
  logic [VSIZE-1:0]             served;
  logic [VSIZE-1:0]             pending_nxt;
  logic [16:0]                  cnt_sum;

  logic [DBW-1:0]               mem [VSIZE][2**HBW];
  logic [DBW-1:0]               rd_word [VSIZE];
  logic [DBW-1:0]               bank_q [VSIZE];

  function automatic logic [CV_BW-1:0] xor_term(input logic [HBW-1:0] hi,
                                                input logic [CV_BW-1:0] mask,
                                                input logic [SBW-1:0] sh);
    logic [HBW-1:0] t;
    t = hi >> sh;
    return t[CV_BW-1:0] & mask;
  endfunction

  always_comb begin
    rmask  = '0;
    rshift = '0;
    wmask  = '0;
    wshift = '0;
    for (int c = 0; c < N_ICFG; c++) begin
      if (rid_q == ICFG_BW'(c)) begin
        rmask  = i_xor_masks[c];
        rshift = i_xor_shifts[c];
      end
      if (i_wid == ICFG_BW'(c)) begin
        wmask  = i_xor_masks[c];
        wshift = i_xor_shifts[c];
      end
    end
  end

  assign wx = xor_term(i_whiaddr, wmask, wshift);

  always_comb begin
    lane_bank = '0;
    lane_row  = '0;
    for (int l = 0; l < VSIZE; l++) begin
      lane_row[l]  = addr_q[l][LBW-1:CV_BW];
      lane_bank[l] = addr_q[l][CV_BW-1:0] ^ xor_term(lane_row[l], rmask, rshift);
    end
  end

  // Descending scan so the lowest pending lane owns each bank's row this round.
  always_comb begin
    bank_row = '0;
    served   = '0;
    for (int l = VSIZE - 1; l >= 0; l--) begin
      if (pending[l]) bank_row[lane_bank[l]] = lane_row[l];
    end
    for (int l = 0; l < VSIZE; l++) begin
      served[l] = pending[l] && (bank_row[lane_bank[l]] == lane_row[l]);
    end
  end

  assign pending_nxt = pending & ~served;
  assign cnt_sum     = {1'b0, o_conflict_cnt} + 17'(rounds) - 17'd1;

  // Lane l's write word lands in bank l^wx; XOR is its own inverse, so bank b takes lane b^wx.
  always_ff @(posedge i_clk) begin
    if (wad_dval) begin
      for (int b = 0; b < VSIZE; b++) begin
        mem[b][i_whiaddr] <= i_wdata[CV_BW'(b) ^ wx];
      end
    end
  end

`ifdef REMAP_CACHE_WBYPASS_EN
  always_comb begin
    for (int b = 0; b < VSIZE; b++) begin
      if (wad_dval && (i_whiaddr == bank_row[b])) rd_word[b] = i_wdata[CV_BW'(b) ^ wx];
      else                                       rd_word[b] = mem[b][bank_row[b]];
    end
  end
`else
  always_comb begin
    for (int b = 0; b < VSIZE; b++) begin
      rd_word[b] = mem[b][bank_row[b]];
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < VSIZE; b++) begin
      bank_q[b] <= rd_word[b];
    end
  end

  assign rd_rdy = (state == S_OUT);
  assign ra_ack = ra_rdy && (state == S_IDLE) && !i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      rid_q          <= '0;
      retire_q       <= 1'b0;
      pending        <= '0;
      served_q       <= '0;
      lane_bank_q    <= '0;
      rounds         <= '0;
      o_syst_type    <= '0;
      o_rdata        <= '0;
      free_dval      <= 1'b0;
      o_free_id      <= '0;
      o_conflict_cnt <= '0;
    end else begin
      free_dval <= 1'b0;
      served_q  <= '0;
      // Previous round's bank words land in the lanes that round served.
      for (int l = 0; l < VSIZE; l++) begin
        if (served_q[l]) o_rdata[l] <= bank_q[lane_bank_q[l]];
      end
      case (state)
        S_IDLE: begin
          if (ra_rdy) begin
            addr_q      <= i_raddr;
            rid_q       <= i_rid;
            retire_q    <= i_retire;
            o_syst_type <= i_syst_type;
            pending     <= '1;
            rounds      <= '0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          served_q    <= served;
          lane_bank_q <= lane_bank;
          pending     <= pending_nxt;
          rounds      <= rounds + (CV_BW + 1)'(1);
          if (pending_nxt == '0) state <= S_DRAIN;
        end
        S_DRAIN: begin
          o_conflict_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
          state          <= S_OUT;
        end
        S_OUT: begin
          if (rd_ack) begin
            if (retire_q) begin
              free_dval <= 1'b1;
              o_free_id <= rid_q;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remap_bank_cache.sv
// tb/tb_remap_bank_cache.sv - directed self-checking bench for remap_bank_cache.
module tb_remap_bank_cache;

  logic              clk;
  logic              rst;
  logic [3:0][1:0]   masks;
  logic [3:0][2:0]   shifts;
  logic              ra_rdy;
  logic              ra_ack;
  logic [2:0]        rid;
  logic [3:0][5:0]   raddr;
  logic              retire;
  logic [1:0]        st;
  logic              rd_rdy;
  logic              rd_ack;
  logic [1:0]        o_st;
  logic [3:0][15:0]  rdata;
  logic              free_dval;
  logic [2:0]        free_id;
  logic [15:0]       ccnt;
  logic              wad_dval;
  logic [2:0]        wid;
  logic [3:0]        whi;
  logic [3:0][15:0]  wdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] byp_exp;

  remap_bank_cache dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_xor_masks    (masks),
    .i_xor_shifts   (shifts),
    .ra_rdy         (ra_rdy),
    .ra_ack         (ra_ack),
    .i_rid          (rid),
    .i_raddr        (raddr),
    .i_retire       (retire),
    .i_syst_type    (st),
    .rd_rdy         (rd_rdy),
    .rd_ack         (rd_ack),
    .o_syst_type    (o_st),
    .o_rdata        (rdata),
    .free_dval      (free_dval),
    .o_free_id      (free_id),
    .o_conflict_cnt (ccnt),
    .wad_dval       (wad_dval),
    .i_wid          (wid),
    .i_whiaddr      (whi),
    .i_wdata        (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] v4(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [23:0] a4(input logic [5:0] a, input logic [5:0] b,
                                     input logic [5:0] c, input logic [5:0] d);
    return {d, c, b, a};
  endfunction

  task automatic write_row(input logic [2:0] id, input logic [3:0] row, input logic [63:0] d);
    wid = id; whi = row; wdata = d; wad_dval = 1'b1;
    @(posedge clk); #1;
    wad_dval = 1'b0;
  endtask

  task automatic start_read(input logic [2:0] id, input logic [23:0] a, input logic ret,
                            input logic [1:0] t);
    rid = id; raddr = a; retire = ret; st = t; ra_rdy = 1'b1;
    #1;
    check_eq("ra_ack_idle", 64'(ra_ack), 64'd1);
    @(posedge clk); #1;
    ra_rdy = 1'b0;
  endtask

  task automatic wait_rdy(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (!rd_rdy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 64'(n), 64'(exp_edges));
  endtask

  task automatic ack_read();
    rd_ack = 1'b1;
    @(posedge clk); #1;
    rd_ack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ra_rdy = 1'b0; rd_ack = 1'b0; wad_dval = 1'b0;
    rid = '0; raddr = '0; retire = 1'b0; st = '0; wid = '0; whi = '0; wdata = '0;
    masks[0] = 2'd0; shifts[0] = 3'd0;
    masks[1] = 2'd3; shifts[1] = 3'd0;
    masks[2] = 2'd0; shifts[2] = 3'd0;
    masks[3] = 2'd1; shifts[3] = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    ra_rdy = 1'b1;
    #1;
    check_eq("rst_ra_ack", 64'(ra_ack), 64'd0);
    ra_rdy = 1'b0;
    check_eq("rst_rd_rdy", 64'(rd_rdy), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    check_eq("rst_syst", 64'(o_st), 64'd0);
    check_eq("rst_free", 64'(free_dval), 64'd0);
    check_eq("rst_free_id", 64'(free_id), 64'd0);
    check_eq("rst_cnt", 64'(ccnt), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // cfg0 identity mapping: rows 0..3
    write_row(3'd0, 4'd0, v4(100, 101, 102, 103));
    write_row(3'd0, 4'd1, v4(110, 111, 112, 113));
    write_row(3'd0, 4'd2, v4(10, 11, 12, 13));
    write_row(3'd0, 4'd3, v4(130, 131, 132, 133));

    start_read(3'd0, a4(8, 9, 10, 11), 1'b0, 2'b01);
    wait_rdy("t1_lat", 2);
    check_eq("t1_data", 64'(rdata), v4(10, 11, 12, 13));
    check_eq("t1_syst", 64'(o_st), 64'd1);
    check_eq("t1_cnt", 64'(ccnt), 64'd0);
    ack_read();
    check_eq("t1_nofree", 64'(free_dval), 64'd0);

    // all lanes in bank 0 -> four rounds
    start_read(3'd0, a4(0, 4, 8, 12), 1'b0, 2'b00);
    wait_rdy("t2_lat", 5);
    check_eq("t2_data", 64'(rdata), v4(100, 110, 10, 130));
    check_eq("t2_cnt", 64'(ccnt), 64'd3);
    ack_read();

    // cfg1 mask 3: row 1 lanes go to banks l^1
    write_row(3'd1, 4'd1, v4(20, 21, 22, 23));
    start_read(3'd1, a4(4, 5, 6, 7), 1'b0, 2'b00);
    wait_rdy("t3_lat", 2);
    check_eq("t3_data", 64'(rdata), v4(20, 21, 22, 23));
    ack_read();
    start_read(3'd1, a4(0, 4, 8, 12), 1'b0, 2'b00);
    wait_rdy("t3_nocfl_lat", 2);
    check_eq("t3_nocfl_data", 64'(rdata), v4(100, 20, 12, 133));
    check_eq("t3_cnt", 64'(ccnt), 64'd3);
    ack_read();

    start_read(3'd0, a4(5, 5, 5, 5), 1'b0, 2'b00);
    wait_rdy("bcast_lat", 2);
    check_eq("bcast_data", 64'(rdata), v4(20, 20, 20, 20));
    check_eq("bcast_cnt", 64'(ccnt), 64'd3);
    ack_read();

    // lanes 0/3 broadcast on bank1 row0, lane1 conflicts on bank1 row1
    start_read(3'd0, a4(1, 5, 2, 1), 1'b0, 2'b00);
    wait_rdy("mix_lat", 3);
    check_eq("mix_data", 64'(rdata), v4(101, 20, 102, 101));
    check_eq("mix_cnt", 64'(ccnt), 64'd4);
    ack_read();

    start_read(3'd2, a4(8, 9, 10, 11), 1'b1, 2'b10);
    wait_rdy("ret_lat", 2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("ret_hold_rdy", 64'(rd_rdy), 64'd1);
      check_eq("ret_hold_data", 64'(rdata), v4(10, 11, 12, 13));
      check_eq("ret_hold_nofree", 64'(free_dval), 64'd0);
    end
    check_eq("ret_syst", 64'(o_st), 64'd2);
    ra_rdy = 1'b1;
    #1;
    check_eq("ret_ra_ack_busy", 64'(ra_ack), 64'd0);
    ra_rdy = 1'b0;
    ack_read();
    check_eq("ret_free", 64'(free_dval), 64'd1);
    check_eq("ret_free_id", 64'(free_id), 64'd2);
    @(posedge clk); #1;
    check_eq("ret_free_once", 64'(free_dval), 64'd0);

    // reset during ISSUE of a retiring request
    start_read(3'd0, a4(0, 4, 8, 12), 1'b1, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    ra_rdy = 1'b1;
    #1;
    check_eq("mrst_ra_ack", 64'(ra_ack), 64'd0);
    check_eq("mrst_rd_rdy", 64'(rd_rdy), 64'd0);
    check_eq("mrst_rdata", 64'(rdata), 64'd0);
    check_eq("mrst_syst", 64'(o_st), 64'd0);
    check_eq("mrst_cnt", 64'(ccnt), 64'd0);
    ra_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("mrst_nofree", 64'(free_dval), 64'd0);
      check_eq("mrst_idle", 64'(rd_rdy), 64'd0);
    end

`ifdef REMAP_CACHE_WBYPASS_EN
    byp_exp = 16'd200;
`else
    byp_exp = 16'd130;
`endif
    // write bank0 row3 in the same cycle the read of it issues
    start_read(3'd0, a4(12, 12, 12, 12), 1'b0, 2'b00);
    wid = 3'd0; whi = 4'd3; wdata = v4(200, 201, 202, 203); wad_dval = 1'b1;
    @(posedge clk); #1;
    wad_dval = 1'b0;
    wait_rdy("byp_lat", 1);
    check_eq("byp_data", 64'(rdata), v4(byp_exp, byp_exp, byp_exp, byp_exp));
    check_eq("byp_cnt", 64'(ccnt), 64'd0);
    ack_read();
    start_read(3'd0, a4(12, 12, 12, 12), 1'b0, 2'b00);
    wait_rdy("post_wr_lat", 2);
    check_eq("post_wr_data", 64'(rdata), v4(200, 200, 200, 200));
    ack_read();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/remap_bank_cache.md
# remap_bank_cache

Successor to the single-round banked remap cache in the TileAccumUnit read pipeline. Serves one vector read of VSIZE lane addresses per request out of VSIZE XOR-remapped two-port SRAM banks. Bank conflicts are serialised over multiple rounds instead of being forbidden, and lanes that hit the same word are broadcast. Sits between the address generator (ra) and the systolic/alu input stage (rd); the DRAM fill path writes through the wad port.

## Interface
- LBW, 6: local address width per lane.
- DBW, 16: data word width.
- VSIZE, 4: lane count = bank count, power of two, ≥2.
- N_ICFG, 4: number of remap configurations / block IDs.
- Derived: CV_BW=$clog2(VSIZE), HBW=LBW-CV_BW, ICFG_BW=$clog2(N_ICFG+1), SBW=$clog2(HBW+1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_xor_masks  in  [CV_BW] x N_ICFG  per-config bank XOR mask.
- i_xor_shifts  in  [SBW] x N_ICFG  per-config right shift of hi address.
- ra_rdy / ra_ack  in / out  1  read-request handshake.
- i_rid  in  ICFG_BW  config/block ID of request.
- i_raddr  in  [LBW] x VSIZE  lane addresses.
- i_retire  in  1  last read of block i_rid.
- i_syst_type  in  2  passthrough tag.
- rd_rdy / rd_ack  out / in  1  read-data handshake.
- o_syst_type  out  2  tag of delivered request.
- o_rdata  out  [DBW] x VSIZE  lane-ordered read data.
- free_dval  out  1  one-cycle block-free pulse.
- o_free_id  out  ICFG_BW  freed ID.
- o_conflict_cnt  out  16  saturating count of extra rounds.
- wad_dval  in  1  write strobe, no back-pressure.
- i_wid  in  ICFG_BW  config for write remap.
- i_whiaddr  in  HBW  write row.
- i_wdata  in  [DBW] x VSIZE  lane-ordered write data.

## Operation
- Mapping for config c: lo=addr[CV_BW-1:0], hi=addr[LBW-1:CV_BW]; bank=lo ^ ((hi>>shift[c]) & mask[c]) truncated to CV_BW; row=hi.
- Write: lane l word goes to bank (l ^ ((i_whiaddr>>shift[i_wid]) & mask[i_wid])), row i_whiaddr; always a permutation, one cycle, all banks.
- FSM IDLE, ISSUE, DRAIN, OUT.
  - IDLE: ra_ack=ra_rdy. On accept, register addresses, rid, retire, syst_type; pending=all ones -> ISSUE.
  - ISSUE: per bank, select lowest-index pending lane mapped to it; all pending lanes with the same bank and row join it (broadcast). Issue SRAM reads, clear served lanes. When pending becomes zero -> DRAIN.
  - DRAIN: capture last round -> OUT.
  - OUT: rd_rdy=1, data/tag stable until rd_ack. On ack, if retire: free_dval=1, o_free_id=rid next cycle. -> IDLE.
- Each round's data is captured into the served lanes' o_rdata slots the cycle after issue; unserved lanes keep their value.
- o_conflict_cnt += (rounds-1) on entering OUT; saturates at 0xFFFF.
- Two-port banks: writes never stall reads. Same bank/row read and write in one cycle return old data (see Configuration).

## Timing
- Accept at cycle T; round k issued at T+k; rd_rdy first high at T+R+2 for R rounds (conflict-free: T+3). One request in flight; ra_ack low outside IDLE.
- free_dval exactly one cycle, at ack cycle +1.
- Reset values: rd_rdy 0, ra_ack 0, o_rdata all 0, o_syst_type 0, free_dval 0, o_free_id 0, o_conflict_cnt 0, FSM IDLE.
- Reset mid-request drops it silently, with no free pulse. SRAM contents are not cleared.
- rd_ack while rd_rdy is low is ignored.
- i_rid ≥ N_ICFG is illegal and has undefined mapping.

## Configuration
- REMAP_CACHE_WBYPASS_EN defined: a read issued in the same cycle as a write to the same bank and row captures the write data (forwarding mux per bank).
- Undefined: such a read returns the previous SRAM contents. No mux is compiled.

## Test plan
- VSIZE=4, LBW=6, cfg0 mask 0 shift 0. Write row 2 data {10,11,12,13}, then read {8,9,10,11} -> o_rdata {10,11,12,13}, rd_rdy at T+3, cnt stays 0.
- cfg0 read {0,4,8,12} (all bank 0) -> 4 rounds, rd_rdy at T+6, o_conflict_cnt=3, data equals rows 0..3 bank 0.
- cfg1 mask 3 shift 0. Write row 1 {20,21,22,23}, then read {4,5,6,7} -> {20,21,22,23}. Read {0,4,8,12} -> conflict-free, T+3.
- Broadcast: read {5,5,5,5} -> one round, all lanes equal word at addr 5.
- Retire=1, rid=2, rd_ack held low 3 cycles -> rd_rdy and data stable. free_dval single pulse, o_free_id=2, one cycle after ack. Assert i_rst during ISSUE -> all outputs zero, no free pulse.
- Same-cycle write row 3 bank 0 plus read of it -> new data with REMAP_CACHE_WBYPASS_EN, old data without.
